// File: rtl/axis_csum_pkg.sv
// Shared types and ones'-complement helper for the AXI-Stream checksum appender.
package axis_csum_pkg;

    localparam int unsigned CSUM_DW = 16;
    localparam logic [CSUM_DW-1:0] CSUM_INIT = '0;

    typedef enum logic {
        PASS,
        APPEND
    } state_t;

    // Single end-around carry fold is enough: a + b + 1 never overflows twice.
    function automatic logic [CSUM_DW-1:0] oc_add(input logic [CSUM_DW-1:0] a,
                                                  input logic [CSUM_DW-1:0] b);
        logic [CSUM_DW:0] t;
        t = {1'b0, a} + {1'b0, b};
        return t[CSUM_DW-1:0] + {{(CSUM_DW-1){1'b0}}, t[CSUM_DW]};
    endfunction

endpackage

// File: rtl/axis_csum_append.sv
// Passes an AXI-Stream packet through and appends a ones'-complement checksum beat,
// counting packets and force-terminating any that reach MAX_LEN beats.
module axis_csum_append
    import axis_csum_pkg::*;
#(
    parameter int unsigned DW      = CSUM_DW,  // oc_add runs at CSUM_DW; keep these equal
    parameter int unsigned MAX_LEN = 1024,
    parameter int unsigned LW      = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] s_tdata,
    input  logic          s_tvalid,
    input  logic          s_tlast,
    output logic          s_tready,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    output logic          m_tlast,
    input  logic          m_tready,
    output logic [15:0]   pkt_count,
    output logic          err_len
);

    state_t        state_q, state_d;
    logic [DW-1:0] sum_q, sum_d;
    logic [LW-1:0] beat_cnt_q, beat_cnt_d;
    logic [DW-1:0] m_tdata_q, m_tdata_d;
    logic          m_tvalid_q, m_tvalid_d;
    logic          m_tlast_q, m_tlast_d;
    logic [15:0]   pkt_count_q, pkt_count_d;
    logic          err_len_q, err_len_d;
    logic          run_q;

    logic          slot_free;
    logic          accept;
    logic [LW-1:0] beat_cnt_inc;
    logic          at_max;

    assign slot_free    = !m_tvalid_q || m_tready;
    // run_q keeps s_tready low while reset is asserted and for the first cycle after.
    assign s_tready     = run_q && (state_q == PASS) && slot_free;
    assign accept       = s_tvalid && s_tready;
    assign beat_cnt_inc = beat_cnt_q + LW'(1);
    assign at_max       = (beat_cnt_inc == LW'(MAX_LEN));

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        beat_cnt_d  = beat_cnt_q;
        m_tdata_d   = m_tdata_q;
        m_tlast_d   = m_tlast_q;
        m_tvalid_d  = m_tvalid_q && !m_tready;
        err_len_d   = 1'b0;
        pkt_count_d = pkt_count_q;

        if (m_tvalid_q && m_tready && m_tlast_q) begin
            pkt_count_d = pkt_count_q + 16'd1;
        end

        unique case (state_q)
            PASS: begin
                if (accept) begin
                    m_tdata_d  = s_tdata;
                    m_tlast_d  = 1'b0;
                    m_tvalid_d = 1'b1;
                    sum_d      = oc_add(sum_q, s_tdata);
                    beat_cnt_d = beat_cnt_inc;
                    if (s_tlast || at_max) begin
                        state_d = APPEND;
                    end
                    err_len_d = at_max && !s_tlast;
                end
            end
            APPEND: begin
                if (slot_free) begin
                    m_tdata_d  = ~sum_q;
                    m_tlast_d  = 1'b1;
                    m_tvalid_d = 1'b1;
                    sum_d      = CSUM_INIT;
                    beat_cnt_d = '0;
                    state_d    = PASS;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PASS;
            sum_q       <= CSUM_INIT;
            beat_cnt_q  <= '0;
            m_tdata_q   <= '0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
            pkt_count_q <= '0;
            err_len_q   <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            beat_cnt_q  <= beat_cnt_d;
            m_tdata_q   <= m_tdata_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tlast_q   <= m_tlast_d;
            pkt_count_q <= pkt_count_d;
            err_len_q   <= err_len_d;
            run_q       <= 1'b1;
        end
    end

    assign m_tdata   = m_tdata_q;
    assign m_tvalid  = m_tvalid_q;
    assign m_tlast   = m_tlast_q;
    assign pkt_count = pkt_count_q;
    assign err_len   = err_len_q;

endmodule

// File: tb/tb_axis_csum_append.sv
// Directed bench for axis_csum_append: scoreboard of expected output beats, MAX_LEN=4.
module tb_axis_csum_append;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [15:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready = 1'b1;
    logic [15:0] pkt_count;
    logic        err_len;

    int          n_checks = 0;
    int          n_pass = 0;
    int          err_seen = 0;
    int          stall_seen = 0;
    logic [16:0] sb[$];
    logic        stall = 1'b0;
    logic [15:0] hold_d;
    logic        hold_l;

    axis_csum_append #(
        .DW      (16),
        .MAX_LEN (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tlast   (s_tlast),
        .s_tready  (s_tready),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tlast   (m_tlast),
        .m_tready  (m_tready),
        .pkt_count (pkt_count),
        .err_len   (err_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Drive one beat, wait (bounded) for acceptance; returns just after the accepting edge.
    task automatic send(input logic [15:0] d, input logic l);
        int   cyc;
        logic done;
        sb.push_back({1'b0, d});
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        done     = 1'b0;
        cyc      = 0;
        while (!done && cyc < 50) begin
            @(negedge clk);
            if (s_tready) done = 1'b1;
            cyc++;
        end
        if (done) begin
            @(posedge clk);
            #1;
        end
        chk("beat_accepted", {31'd0, done}, 32'd1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic expect_csum(input logic [15:0] d);
        sb.push_back({1'b1, d});
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (sb.size() != 0 && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk("drain_empty", sb.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Output monitor: pops the scoreboard on every handshake and checks stall stability.
    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst_n) begin
            stall = 1'b0;
        end else begin
            if (err_len) err_seen++;
            if (stall) begin
                chk("hold_valid", {31'd0, m_tvalid}, 32'd1);
                chk("hold_data", {16'd0, m_tdata}, {16'd0, hold_d});
                chk("hold_last", {31'd0, m_tlast}, {31'd0, hold_l});
            end
            stall  = m_tvalid && !m_tready;
            hold_d = m_tdata;
            hold_l = m_tlast;
            if (stall) stall_seen++;
            if (m_tvalid && m_tready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $error("FAIL extra_beat: observed data 0x%0h last %0b expected none",
                           m_tdata, m_tlast);
                end else begin
                    e = sb.pop_front();
                    chk("beat_data", {16'd0, m_tdata}, {16'd0, e[15:0]});
                    chk("beat_last", {31'd0, m_tlast}, {31'd0, e[16]});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        #23;
        chk("rst_s_tready", {31'd0, s_tready}, 32'd0);
        chk("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("rst_m_tlast", {31'd0, m_tlast}, 32'd0);
        chk("rst_m_tdata", {16'd0, m_tdata}, 32'd0);
        chk("rst_pkt_count", {16'd0, pkt_count}, 32'd0);
        chk("rst_err_len", {31'd0, err_len}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic two-beat packet
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b1);
        expect_csum(16'hFFFC);
        drain();
        chk("pkt_count_t1", {16'd0, pkt_count}, 32'd1);

        // End-around carry
        send(16'hFFFF, 1'b0);
        send(16'h0001, 1'b1);
        expect_csum(16'hFFFE);
        drain();
        chk("pkt_count_t2", {16'd0, pkt_count}, 32'd2);

        // Back-to-back single-beat packets with a one-cycle gap
        send(16'h1234, 1'b1);
        expect_csum(16'hEDCB);
        @(negedge clk);
        chk("gap_ready_low", {31'd0, s_tready}, 32'd0);
        @(negedge clk);
        chk("gap_ready_high", {31'd0, s_tready}, 32'd1);
        @(posedge clk);
        #1;
        send(16'h0010, 1'b1);
        expect_csum(16'hFFEF);
        drain();
        chk("pkt_count_t3", {16'd0, pkt_count}, 32'd4);

        // Downstream backpressure
        fork
            begin
                send(16'h0100, 1'b0);
                send(16'h0200, 1'b0);
                send(16'h0300, 1'b1);
                expect_csum(16'hF9FF);
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    m_tready = pat[i];
                    @(posedge clk);
                    #1;
                end
                m_tready = 1'b1;
            end
        join
        drain();
        chk("stall_exercised", {31'd0, stall_seen > 0}, 32'd1);
        chk("pkt_count_t4", {16'd0, pkt_count}, 32'd5);
        chk("no_err_yet", err_seen, 32'd0);

        // Forced termination at MAX_LEN, remainder forms a new packet
        for (int i = 0; i < 4; i++) send(16'h0001, 1'b0);
        expect_csum(16'hFFFB);
        send(16'h0001, 1'b0);
        send(16'h0001, 1'b1);
        expect_csum(16'hFFFD);
        drain();
        chk("pkt_count_t5", {16'd0, pkt_count}, 32'd7);
        chk("err_len_pulses", err_seen, 32'd1);

        // Reset in mid-packet discards the partial packet
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("mid_rst_m_tdata", {16'd0, m_tdata}, 32'd0);
        chk("mid_rst_m_tlast", {31'd0, m_tlast}, 32'd0);
        chk("mid_rst_pkt_count", {16'd0, pkt_count}, 32'd0);
        chk("mid_rst_s_tready", {31'd0, s_tready}, 32'd0);
        chk("mid_rst_err_len", {31'd0, err_len}, 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(16'h0005, 1'b1);
        expect_csum(16'hFFFA);
        drain();
        chk("pkt_count_t6", {16'd0, pkt_count}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
